demux4_dispatch_64: RTL and testbench
=====================================

DEMUX4_DISPATCH_64 -- requirements
Module: demux4_dispatch_64

Interface
REQ-001 SHALL have parameter DATA_W, default 64, result datapath width.
REQ-002 SHALL have parameter CNT_W, default 16, width of per-channel transfer counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream result present.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_sel  input  2  destination: 00, 01, 10, 11 select channels 0-3.
REQ-008 SHALL have port in_data  input  DATA_W  result word.
REQ-009 SHALL have port out_valid  output  4  per-channel slot holds data.
REQ-010 SHALL have port out_ready  input  4  per-channel consumer accepts.
REQ-011 SHALL have ports out_data_00, out_data_01, out_data_10, out_data_11  output  DATA_W  per-channel registered data.
REQ-012 SHALL have port out_cnt  output  4*CNT_W  per-channel completed-transfer counts; channel n at bits [n*CNT_W +: CNT_W]. Present only with DEMUX_CNT_EN.

Function
REQ-013 SHALL be the inverse of the 4:1 64-bit result mux: one input stream, routed to exactly one of four outputs by in_sel.
REQ-014 SHALL hold one single-entry slot per channel, each with two states, EMPTY and FULL.
REQ-015 SHALL transfer input when in_valid && in_ready; the accept occurs on that clock edge.
REQ-016 SHALL drive in_ready = (slot[in_sel] EMPTY) || out_ready[in_sel], combinationally and independent of in_valid.
REQ-017 SHALL transfer output n when out_valid[n] && out_ready[n].
REQ-018 SHALL assert out_valid[n] exactly when slot n is FULL; out_data_n SHALL be stable while FULL and not transferred.
REQ-019 SHALL present accepted data on out_data_n with out_valid[n] high in the cycle after accept (latency 1 cycle).
REQ-020 SHALL move slot n EMPTY->FULL on accept with no drain, FULL->EMPTY on drain with no accept, and stay FULL while loading new data on a same-cycle drain and accept to n.
REQ-021 SHALL keep non-selected slots unaffected by an input accept; draining channels operate independently and concurrently.
REQ-022 SHALL ignore in_sel and in_data when in_valid is low.
REQ-023 SHALL sustain one accept per cycle to a single channel whose out_ready is held high.
REQ-024 SHALL, with DEMUX_CNT_EN, increment channel n's counter on each output transfer n, wrapping modulo 2^CNT_W with no saturation.

Reset
REQ-025 SHALL, while rst is high, immediately force all slots EMPTY, out_valid=4'b0000, all out_data_n=0 and all out_cnt fields=0, independent of clk.
REQ-026 SHALL discard data held in a slot when reset asserts mid-transfer; the first accept after reset release SHALL behave as from the initial state.

Configuration
REQ-027 SHALL use macro DEMUX4_DISPATCH_CNT_EN. When defined, it SHALL build the out_cnt port and counters. When undefined, it SHALL omit out_cnt and the counters, and all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the DATA_W default, CNT_W default and the channel-select encoding constants (SEL_00, SEL_01, SEL_10, SEL_11) in shared package calc_pkg.
REQ-029 SHALL implement each slot as sub-module demux_slot, instantiated four times, with inputs load, drain and data and outputs full and q.

Verification
REQ-030 Reset: assert rst mid-cycle with slot 2 FULL -> out_valid=0000 and out_data_10=0 immediately, before any clk edge.
REQ-031 Single route: in_sel=01, in_data=64'hDEAD_BEEF_0000_0001, out_ready=0000 -> next cycle out_valid=0010, out_data_01 matches; a second in_valid to channel 01 sees in_ready=0.
REQ-032 Back-to-back: out_ready[3]=1, 8 consecutive words to sel=11 -> in_ready stays 1, 8 outputs in order, 1-cycle latency each.
REQ-033 Blocking isolation: slot 0 FULL with out_ready[0]=0, input to sel=10 -> in_ready=1 and channel 2 receives the word; slot 0 data unchanged.
REQ-034 Simultaneous drain and load: slot 1 FULL with value A, out_ready[1]=1, input B to sel=01 -> A is consumed this cycle, and B is valid next cycle with no bubble.
REQ-035 Counter wrap (DEMUX4_DISPATCH_CNT_EN): 65536 transfers on channel 0 -> out_cnt[15:0] returns to 0; build without the macro elaborates with no out_cnt port.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and types for the 4-way result dispatcher: width defaults,
// channel-select encoding and the per-channel slot state.
package calc_pkg;

   localparam int DATA_W_DEFAULT = 64;
   localparam int CNT_W_DEFAULT  = 16;
   localparam int N_CH           = 4;

   typedef enum logic [1:0] {
      SEL_00 = 2'b00,
      SEL_01 = 2'b01,
      SEL_10 = 2'b10,
      SEL_11 = 2'b11
   } sel_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output slot: loads on 'load', empties on 'drain' unless reloaded
// in the same cycle, in which case it stays FULL with the new word.
module demux_slot
   import calc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] data,
   output logic              full,
   output logic [DATA_W-1:0] q
);

   slot_state_e       state_q, state_d;
   logic [DATA_W-1:0] data_q,  data_d;

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path can infer a latch.
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         EMPTY:   if (load)           state_d = FULL;
         FULL:    if (drain && !load) state_d = EMPTY;
         default:                     state_d = EMPTY;
      endcase
      if (load) data_d = data;
   end

   // NOTE: state uses non-blocking assignments; the data register is reset too
   // because a cleared output word is part of the visible reset state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign full = (state_q == FULL);
   assign q    = data_q;

endmodule

// File: rtl/demux4_dispatch_64.sv
// 1:4 result dispatcher with a single-entry slot per channel. Define
// DEMUX4_DISPATCH_CNT_EN to add per-channel completed-transfer counters (out_cnt).
module demux4_dispatch_64
   import calc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int CNT_W  = CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_sel,
   input  logic [DATA_W-1:0]    in_data,
   output logic [N_CH-1:0]      out_valid,
   input  logic [N_CH-1:0]      out_ready,
`ifdef DEMUX4_DISPATCH_CNT_EN
   output logic [N_CH*CNT_W-1:0] out_cnt,
`endif
   output logic [DATA_W-1:0]    out_data_00,
   output logic [DATA_W-1:0]    out_data_01,
   output logic [DATA_W-1:0]    out_data_10,
   output logic [DATA_W-1:0]    out_data_11
);

   if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
      $error("demux4_dispatch_64: DATA_W and CNT_W must be positive");
   end

   logic [N_CH-1:0]   full;
   logic [N_CH-1:0]   load;
   logic [N_CH-1:0]   drain;
   logic [DATA_W-1:0] q [N_CH];
   logic              accept;

   // Ready looks only at the addressed slot, so a stalled channel never blocks others.
   assign in_ready  = !full[in_sel] || out_ready[in_sel];
   assign accept    = in_valid && in_ready;
   assign drain     = full & out_ready;
   assign out_valid = full;

   always_comb begin
      load = '0;
      case (sel_e'(in_sel))
         SEL_00:  load[0] = accept;
         SEL_01:  load[1] = accept;
         SEL_10:  load[2] = accept;
         SEL_11:  load[3] = accept;
         default: load    = '0;
      endcase
   end

   for (genvar n = 0; n < N_CH; n++) begin : g_slot
      demux_slot #(.DATA_W(DATA_W)) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load[n]),
         .drain (drain[n]),
         .data  (in_data),
         .full  (full[n]),
         .q     (q[n])
      );
   end

   assign out_data_00 = q[0];
   assign out_data_01 = q[1];
   assign out_data_10 = q[2];
   assign out_data_11 = q[3];

`ifdef DEMUX4_DISPATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];

   // Free-running counts wrap naturally at 2^CNT_W.
   always_comb begin
      for (int n = 0; n < N_CH; n++) cnt_d[n] = cnt_q[n] + CNT_W'(drain[n]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < N_CH; n++) cnt_q[n] <= '0;
      end else begin
         for (int n = 0; n < N_CH; n++) cnt_q[n] <= cnt_d[n];
      end
   end

   for (genvar n = 0; n < N_CH; n++) begin : g_cnt
      assign out_cnt[n*CNT_W +: CNT_W] = cnt_q[n];
   end
`endif

endmodule

// File: tb/tb_demux4_dispatch_64.sv
// Self-checking bench for demux4_dispatch_64; a negedge scoreboard tracks every
// accepted word per channel and checks it against the word the channel delivers.
module tb_demux4_dispatch_64;

   localparam int DW = 64;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_sel;
   logic [DW-1:0] in_data;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [DW-1:0] out_data_00, out_data_01, out_data_10, out_data_11;
`ifdef DEMUX4_DISPATCH_CNT_EN
   logic [4*CW-1:0] out_cnt;
   logic [CW-1:0]   cnt_m [4];
`endif

   logic [DW-1:0] od [4];
   logic [DW-1:0] exp_q [4][$];
   int            n_cmp = 0;
   int            n_err = 0;

   assign od[0] = out_data_00;
   assign od[1] = out_data_01;
   assign od[2] = out_data_10;
   assign od[3] = out_data_11;

   always #5 clk = ~clk;

   demux4_dispatch_64 #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sel      (in_sel),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
`ifdef DEMUX4_DISPATCH_CNT_EN
      .out_cnt     (out_cnt),
`endif
      .out_data_00 (out_data_00),
      .out_data_01 (out_data_01),
      .out_data_10 (out_data_10),
      .out_data_11 (out_data_11)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int n = 0; n < 4; n++) begin
         exp_q[n].delete();
`ifdef DEMUX4_DISPATCH_CNT_EN
         cnt_m[n] = '0;
`endif
      end
   endtask

   task automatic apply_reset();
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      rst       = 1'b1;
      step();
      clear_model();
      step();
      rst = 1'b0;
   endtask

   // Inputs change only at posedge+1, so what is seen at negedge is what the next edge acts on.
   task automatic monitor();
      logic [DW-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int n = 0; n < 4; n++) begin
               if (out_valid[n] && out_ready[n]) begin
                  n_cmp++;
                  if (exp_q[n].size() == 0) begin
                     n_err++;
                     $display("FAIL sb_ch%0d: got %h, expected no output", n, od[n]);
                  end else begin
                     exp = exp_q[n].pop_front();
                     if (od[n] !== exp) begin
                        n_err++;
                        $display("FAIL sb_ch%0d: got %h, expected %h", n, od[n], exp);
                     end
                  end
`ifdef DEMUX4_DISPATCH_CNT_EN
                  cnt_m[n] = cnt_m[n] + 1'b1;
`endif
               end
            end
            if (in_valid && in_ready) exp_q[in_sel].push_back(in_data);
         end
      end
   endtask

   task automatic test_reset();
      logic [DW-1:0] w;
      w = 64'h0123_4567_89AB_CDEF;
      apply_reset();
      n_cmp++;
      if (out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b, expected 0000", out_valid); end
      for (int n = 0; n < 4; n++) begin
         n_cmp++;
         if (od[n] !== '0) begin n_err++; $display("FAIL reset_data%0d: got %h, expected 0", n, od[n]); end
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, expected 1", in_ready); end
`ifdef DEMUX4_DISPATCH_CNT_EN
      n_cmp++;
      if (out_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %h, expected 0", out_cnt); end
`endif
      in_valid = 1'b1; in_sel = 2'b10; in_data = w;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 4'b0100) begin n_err++; $display("FAIL pre_rst_valid: got %b, expected 0100", out_valid); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 4'b0000) begin n_err++; $display("FAIL async_rst_valid: got %b, expected 0000", out_valid); end
      n_cmp++;
      if (out_data_10 !== '0) begin n_err++; $display("FAIL async_rst_data10: got %h, expected 0", out_data_10); end
      clear_model();
      step();
      rst = 1'b0;
      in_valid = 1'b1; in_sel = 2'b10; in_data = ~w;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 4'b0100 || out_data_10 !== ~w) begin
         n_err++;
         $display("FAIL post_rst_accept: got %b/%h, expected 0100/%h", out_valid, out_data_10, ~w);
      end
      out_ready = 4'b0100;
      step();
      out_ready = 4'b0000;
   endtask

   task automatic test_single_route();
      logic [DW-1:0] w;
      w = 64'hDEAD_BEEF_0000_0001;
      out_ready = 4'b0000;
      in_valid = 1'b1; in_sel = 2'b01; in_data = w;
      step();
      n_cmp++;
      if (out_valid !== 4'b0010) begin n_err++; $display("FAIL route_valid: got %b, expected 0010", out_valid); end
      n_cmp++;
      if (out_data_01 !== w) begin n_err++; $display("FAIL route_data: got %h, expected %h", out_data_01, w); end
      in_data = 64'h1111_2222_3333_4444;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL route_blocked_ready: got %b, expected 0", in_ready); end
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_data_01 !== w) begin n_err++; $display("FAIL route_stable: got %h, expected %h", out_data_01, w); end
      out_ready = 4'b0010;
      step();
      out_ready = 4'b0000;
      in_sel = 2'b11; in_data = 64'hFFFF_0000_FFFF_0000;
      step();
      n_cmp++;
      if (out_valid !== 4'b0000) begin n_err++; $display("FAIL idle_ignored: got %b, expected 0000", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w;
      out_ready = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         w = {32'hB2B0_0000, 32'(i * 7 + 3)};
         in_valid = 1'b1; in_sel = 2'b11; in_data = w;
         #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b, expected 1", i, in_ready); end
         step();
         n_cmp++;
         if (out_valid[3] !== 1'b1 || out_data_11 !== w) begin
            n_err++;
            $display("FAIL b2b_latency%0d: got %b/%h, expected 1/%h", i, out_valid[3], out_data_11, w);
         end
      end
      in_valid = 1'b0;
      step();
      out_ready = 4'b0000;
      n_cmp++;
      if (out_valid !== 4'b0000 || exp_q[3].size() != 0) begin
         n_err++;
         $display("FAIL b2b_drained: got %b/%0d pending, expected 0000/0", out_valid, exp_q[3].size());
      end
   endtask

   task automatic test_blocking_isolation();
      logic [DW-1:0] a, b;
      a = 64'hAAAA_0000_0000_AAAA;
      b = 64'hBBBB_0000_0000_BBBB;
      out_ready = 4'b0000;
      in_valid = 1'b1; in_sel = 2'b00; in_data = a;
      step();
      in_sel = 2'b10; in_data = b;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL iso_ready: got %b, expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 4'b0101) begin n_err++; $display("FAIL iso_valid: got %b, expected 0101", out_valid); end
      n_cmp++;
      if (out_data_10 !== b || out_data_00 !== a) begin
         n_err++;
         $display("FAIL iso_data: got %h/%h, expected %h/%h", out_data_00, out_data_10, a, b);
      end
      out_ready = 4'b0101;
      step();
      out_ready = 4'b0000;
   endtask

   task automatic test_simul_drain_load();
      logic [DW-1:0] a, b;
      a = 64'h0000_0000_CAFE_000A;
      b = 64'h0000_0000_CAFE_000B;
      out_ready = 4'b0000;
      in_valid = 1'b1; in_sel = 2'b01; in_data = a;
      step();
      out_ready = 4'b0010; in_data = b;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL sdl_ready: got %b, expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid[1] !== 1'b1 || out_data_01 !== b) begin
         n_err++;
         $display("FAIL sdl_no_bubble: got %b/%h, expected 1/%h", out_valid[1], out_data_01, b);
      end
      step();
      out_ready = 4'b0000;
      n_cmp++;
      if (out_valid !== 4'b0000) begin n_err++; $display("FAIL sdl_empty: got %b, expected 0000", out_valid); end
   endtask

   task automatic test_random_traffic();
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = {$urandom, $urandom};
         out_ready = 4'($urandom_range(0, 15));
         step();
      end
      in_valid = 1'b0; out_ready = 4'b1111;
      step();
      step();
      for (int n = 0; n < 4; n++) begin
         n_cmp++;
         if (exp_q[n].size() != 0) begin
            n_err++;
            $display("FAIL rand_pending%0d: got %0d words outstanding, expected 0", n, exp_q[n].size());
         end
      end
      n_cmp++;
      if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rand_valid: got %b, expected 0000", out_valid); end
`ifdef DEMUX4_DISPATCH_CNT_EN
      n_cmp++;
      if (out_cnt !== {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]}) begin
         n_err++;
         $display("FAIL rand_cnt: got %h, expected %h", out_cnt, {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]});
      end
`endif
      out_ready = 4'b0000;
   endtask

`ifdef DEMUX4_DISPATCH_CNT_EN
   task automatic test_counter_wrap();
      apply_reset();
      out_ready = 4'b0001;
      in_valid = 1'b1; in_sel = 2'b00;
      for (int i = 0; i < 65536; i++) begin
         in_data = 64'(i);
         step();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (out_cnt[CW-1:0] !== 16'hFFFF) begin n_err++; $display("FAIL cnt_max: got %h, expected ffff", out_cnt[CW-1:0]); end
      step();
      out_ready = 4'b0000;
      n_cmp++;
      if (out_cnt[CW-1:0] !== 16'h0000) begin n_err++; $display("FAIL cnt_wrap: got %h, expected 0000", out_cnt[CW-1:0]); end
      n_cmp++;
      if (out_cnt !== {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]}) begin
         n_err++;
         $display("FAIL cnt_model: got %h, expected %h", out_cnt, {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]});
      end
   endtask
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = '0; out_ready = 4'b0000;
`ifdef DEMUX4_DISPATCH_CNT_EN
      for (int n = 0; n < 4; n++) cnt_m[n] = '0;
`endif
      fork
         monitor();
      join_none
      test_reset();
      test_single_route();
      test_back_to_back();
      test_blocking_isolation();
      test_simul_drain_load();
      test_random_traffic();
`ifdef DEMUX4_DISPATCH_CNT_EN
      test_counter_wrap();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
